// File: rtl/fft8_stage2_stream.sv
// Second radix-2 butterfly stage of an 8-point FFT with valid/ready streaming.
// Stage A forms exact (W+1)-bit sums/differences; stage B reduces width, applies the W4 twiddle and registers the outputs.
module fft8_stage2_stream #(
    parameter int W     = 16,
    parameter int SCALE = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           inv,
    input  logic [8*W-1:0] x_re,
    input  logic [8*W-1:0] x_im,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [8*W-1:0] y_re,
    output logic [8*W-1:0] y_im,
    output logic           ovf,
    input  logic           ovf_clr
);
    localparam int WA = W + 1;

    logic                en;
    logic [7:0][WA-1:0]  a_re_next, a_im_next;
    logic [7:0][WA-1:0]  a_re_reg, a_im_reg;
    logic                a_v_reg, a_inv_reg;
    logic [7:0][W-1:0]   r_re, r_im;
    logic [7:0][W-1:0]   b_re_next, b_im_next;
    logic [7:0]          rf_re, rf_im, tw_flag;
    logic                clamp_any;

    // Whole pipeline advances together; a full output that is not taken stalls everything.
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    function automatic logic [WA-1:0] sx(input logic [W-1:0] v);
        return {v[W-1], v};
    endfunction

    // Returns {clamped, result}: halve with round-half-up, or saturate to W bits.
    function automatic logic [W:0] reduce(input logic [WA-1:0] v);
        if (SCALE != 0)
            return {1'b0, W'((v + WA'(1)) >> 1)};
        else if (v[W] != v[W-1])
            return {1'b1, v[W], {(W-1){~v[W]}}};
        else
            return {1'b0, v[W-1:0]};
    endfunction

    // Returns {clamped, -v}; the most negative code has no positive twin.
    function automatic logic [W:0] neg_sat(input logic [W-1:0] v);
        if (v == {1'b1, {(W-1){1'b0}}})
            return {1'b1, 1'b0, {(W-1){1'b1}}};
        return {1'b0, ~v + W'(1)};
    endfunction

    // Stage A: element slots are laid out in output order (sum, sum, diff, diff).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bfly
            localparam int B = 4 * gi;
            assign a_re_next[B]   = sx(x_re[B*W +: W])     + sx(x_re[(B+2)*W +: W]);
            assign a_re_next[B+2] = sx(x_re[B*W +: W])     - sx(x_re[(B+2)*W +: W]);
            assign a_re_next[B+1] = sx(x_re[(B+1)*W +: W]) + sx(x_re[(B+3)*W +: W]);
            assign a_re_next[B+3] = sx(x_re[(B+1)*W +: W]) - sx(x_re[(B+3)*W +: W]);
            assign a_im_next[B]   = sx(x_im[B*W +: W])     + sx(x_im[(B+2)*W +: W]);
            assign a_im_next[B+2] = sx(x_im[B*W +: W])     - sx(x_im[(B+2)*W +: W]);
            assign a_im_next[B+1] = sx(x_im[(B+1)*W +: W]) + sx(x_im[(B+3)*W +: W]);
            assign a_im_next[B+3] = sx(x_im[(B+1)*W +: W]) - sx(x_im[(B+3)*W +: W]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_v_reg   <= 1'b0;
            a_inv_reg <= 1'b0;
            a_re_reg  <= '0;
            a_im_reg  <= '0;
        end else if (en) begin
            a_v_reg   <= in_valid;
            a_inv_reg <= inv;
            a_re_reg  <= a_re_next;
            a_im_reg  <= a_im_next;
        end
    end

    generate
        for (gi = 0; gi < 8; gi++) begin : g_red
            assign {rf_re[gi], r_re[gi]} = reduce(a_re_reg[gi]);
            assign {rf_im[gi], r_im[gi]} = reduce(a_im_reg[gi]);
            if ((gi % 4) == 3) begin : g_tw
                logic [W:0] n_re, n_im;
                assign n_re          = neg_sat(r_re[gi]);
                assign n_im          = neg_sat(r_im[gi]);
                // forward: (re,im) -> (im,-re); inverse: (re,im) -> (-im,re)
                assign b_re_next[gi] = a_inv_reg ? n_im[W-1:0] : r_im[gi];
                assign b_im_next[gi] = a_inv_reg ? r_re[gi] : n_re[W-1:0];
                assign tw_flag[gi]   = a_inv_reg ? n_im[W] : n_re[W];
            end else begin : g_pass
                assign b_re_next[gi] = r_re[gi];
                assign b_im_next[gi] = r_im[gi];
                assign tw_flag[gi]   = 1'b0;
            end
        end
    endgenerate

    assign clamp_any = |{rf_re, rf_im, tw_flag};

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            y_re      <= '0;
            y_im      <= '0;
            ovf       <= 1'b0;
        end else begin
            if (en) begin
                out_valid <= a_v_reg;
                y_re      <= b_re_next;
                y_im      <= b_im_next;
            end
            // A fresh overflow on a valid vector outranks a simultaneous clear.
            ovf <= (en & a_v_reg & clamp_any) | (ovf & ~ovf_clr);
        end
    end
endmodule

// File: tb/tb_fft8_stage2_stream.sv
// Bench for fft8_stage2_stream: directed table, hand sequences and a randomized scoreboard run
// on one full-scale and one halving instance driven by the same stimulus.
module tb_fft8_stage2_stream;
    localparam int W    = 16;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));

    logic           clk, rst, in_valid, inv, out_ready, ovf_clr;
    logic [8*W-1:0] x_re, x_im;
    logic           in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
    logic [8*W-1:0] y_re0, y_im0, y_re1, y_im1;

    fft8_stage2_stream #(.W(W), .SCALE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .inv(inv),
        .x_re(x_re), .x_im(x_im), .out_valid(out_valid0), .out_ready(out_ready),
        .y_re(y_re0), .y_im(y_im0), .ovf(ovf0), .ovf_clr(ovf_clr));

    fft8_stage2_stream #(.W(W), .SCALE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .inv(inv),
        .x_re(x_re), .x_im(x_im), .out_valid(out_valid1), .out_ready(out_ready),
        .y_re(y_re1), .y_im(y_im1), .ovf(ovf1), .ovf_clr(ovf_clr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [8*W-1:0] act, input logic [8*W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [8*W-1:0] put(input logic [8*W-1:0] v, input int k, input int val);
        v[k*W +: W] = W'(val);
        return v;
    endfunction

    function automatic int clampw(input int v, output bit c);
        c = 1'b0;
        if (v > MAXV) begin c = 1'b1; return MAXV; end
        if (v < MINV) begin c = 1'b1; return MINV; end
        return v;
    endfunction

    // Reference: integer butterflies, then halve or clamp, then multiply odd differences by -j / +j.
    function automatic void model(input logic [8*W-1:0] xr, input logic [8*W-1:0] xi, input bit inv_b,
                                  input int scale, output logic [8*W-1:0] yr, output logic [8*W-1:0] yi,
                                  output bit ov);
        int ar[8], ai[8], zr[8], zi[8];
        int t;
        bit c;
        ov = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ar[k] = int'($signed(xr[k*W +: W]));
            ai[k] = int'($signed(xi[k*W +: W]));
        end
        for (int g = 0; g < 8; g += 4) begin
            zr[g]   = ar[g] + ar[g+2];     zi[g]   = ai[g] + ai[g+2];
            zr[g+2] = ar[g] - ar[g+2];     zi[g+2] = ai[g] - ai[g+2];
            zr[g+1] = ar[g+1] + ar[g+3];   zi[g+1] = ai[g+1] + ai[g+3];
            zr[g+3] = ar[g+1] - ar[g+3];   zi[g+3] = ai[g+1] - ai[g+3];
        end
        for (int k = 0; k < 8; k++) begin
            if (scale != 0) begin
                zr[k] = (zr[k] + 1) >>> 1;
                zi[k] = (zi[k] + 1) >>> 1;
            end else begin
                zr[k] = clampw(zr[k], c); ov |= c;
                zi[k] = clampw(zi[k], c); ov |= c;
            end
        end
        for (int g = 3; g < 8; g += 4) begin
            t = zr[g];
            if (!inv_b) begin zr[g] = zi[g];  zi[g] = -t; end
            else        begin zr[g] = -zi[g]; zi[g] = t;  end
            zr[g] = clampw(zr[g], c); ov |= c;
            zi[g] = clampw(zi[g], c); ov |= c;
        end
        for (int k = 0; k < 8; k++) begin
            yr[k*W +: W] = zr[k][W-1:0];
            yi[k*W +: W] = zi[k][W-1:0];
        end
    endfunction

    function automatic logic [8*W-1:0] rnd_vec(input bit full);
        logic [8*W-1:0] v;
        for (int k = 0; k < 8; k++) begin
            if (full) v[k*W +: W] = W'($urandom);
            else      v[k*W +: W] = W'(int'($urandom_range(0, 2000)) - 1000);
        end
        return v;
    endfunction

    typedef struct {
        string          name;
        logic [8*W-1:0] xr, xi;
        bit             inv;
        int             scale;
        logic [8*W-1:0] yr, yi;
        bit             ov;
    } vec_t;

    typedef struct {
        logic [8*W-1:0] yr0, yi0, yr1, yi1;
        bit             ov0, ov1;
    } exp_t;

    exp_t           sb[$];
    bit             mon_en = 1'b0;
    bit             prev_stall = 1'b0;
    logic [8*W-1:0] hold_re, hold_im;
    bit             exp_ov0, exp_ov1;
    int             n_out;

    // Scoreboard monitor: sampled mid-cycle, so every handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && rst) begin
            chk("in_ready0", in_ready0, out_ready || !out_valid0);
            chk("in_ready1", in_ready1, out_ready || !out_valid1);
            if (prev_stall) begin
                chk("stall_valid", out_valid0, 1'b1);
                chk("stall_re", y_re0, hold_re);
                chk("stall_im", y_im0, hold_im);
            end
            if (out_valid0 && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    n_out++;
                    exp_ov0 |= e.ov0;
                    exp_ov1 |= e.ov1;
                    chk("s1_valid", out_valid1, 1'b1);
                    chk("s0_re", y_re0, e.yr0);
                    chk("s0_im", y_im0, e.yi0);
                    chk("s1_re", y_re1, e.yr1);
                    chk("s1_im", y_im1, e.yi1);
                    chk("s0_ovf", ovf0, exp_ov0);
                    chk("s1_ovf", ovf1, exp_ov1);
                end
            end
            if (in_valid && in_ready0) begin
                model(x_re, x_im, inv, 0, e.yr0, e.yi0, e.ov0);
                model(x_re, x_im, inv, 1, e.yr1, e.yi1, e.ov1);
                sb.push_back(e);
            end
            prev_stall = out_valid0 && !out_ready;
            hold_re    = y_re0;
            hold_im    = y_im0;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_ovf();
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
    endtask

    // Sends one vector into an idle pipeline and captures the matching output.
    task automatic send_one(input vec_t v, output logic [8*W-1:0] yr, output logic [8*W-1:0] yi,
                            output bit ov, output int lat);
        x_re = v.xr; x_im = v.xi; inv = v.inv;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        yr = '0; yi = '0; ov = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if ((v.scale != 0) ? out_valid1 : out_valid0) begin
                yr = (v.scale != 0) ? y_re1 : y_re0;
                yi = (v.scale != 0) ? y_im1 : y_im0;
                ov = (v.scale != 0) ? ovf1 : ovf0;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        chk(name, sb.size(), 0);
    endtask

    vec_t           tbl[8];
    logic [8*W-1:0] yr, yi;
    bit             ov;
    int             lat;
    logic [8*W-1:0] bp_re[6], bp_im[6];
    bit             acc, seen;
    int             sent;

    initial begin
        tbl[0] = '{"impulse", put('0, 0, 100), '0, 1'b0, 0, put(put('0, 0, 100), 2, 100), '0, 1'b0};
        tbl[1] = '{"tw_fwd", put('0, 1, 300), put('0, 1, -50), 1'b0, 0,
                   put(put('0, 1, 300), 3, -50), put(put('0, 1, -50), 3, -300), 1'b0};
        tbl[2] = '{"tw_inv", put('0, 1, 300), put('0, 1, -50), 1'b1, 0,
                   put(put('0, 1, 300), 3, 50), put(put('0, 1, -50), 3, 300), 1'b0};
        tbl[3] = '{"sat_full", put(put('0, 0, 32767), 2, 32767), put(put('0, 0, -32768), 2, -32768), 1'b0, 0,
                   put('0, 0, 32767), put('0, 0, -32768), 1'b1};
        tbl[4] = '{"sat_half", put(put('0, 0, 32767), 2, 32767), put(put('0, 0, -32768), 2, -32768), 1'b0, 1,
                   put('0, 0, 32767), put('0, 0, -32768), 1'b0};
        tbl[5] = '{"neg_im_min", '0, put('0, 5, -32768), 1'b0, 0,
                   put('0, 7, -32768), put('0, 5, -32768), 1'b0};
        tbl[6] = '{"neg_re_min", put('0, 5, -32768), '0, 1'b0, 0,
                   put('0, 5, -32768), put('0, 7, 32767), 1'b1};
        tbl[7] = '{"round_half", put(put('0, 1, 301), 3, -1), put(put('0, 1, -51), 3, 2), 1'b0, 1,
                   put(put('0, 1, 150), 3, -26), put(put('0, 1, -24), 3, -151), 1'b0};

        rst = 1'b0; in_valid = 1'b0; inv = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        x_re = '0; x_im = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {out_valid1, out_valid0}, 2'b00);
        chk("rst_y0", y_re0 | y_im0, '0);
        chk("rst_y1", y_re1 | y_im1, '0);
        chk("rst_ovf", {ovf1, ovf0}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            clear_ovf();
            send_one(tbl[i], yr, yi, ov, lat);
            $display("vec %0d %s inv=%0d scale=%0d lat=%0d ovf=%0d", i, tbl[i].name, tbl[i].inv, tbl[i].scale, lat, ov);
            chk({tbl[i].name, "_lat"}, lat, 2);
            chk({tbl[i].name, "_re"}, yr, tbl[i].yr);
            chk({tbl[i].name, "_im"}, yi, tbl[i].yi);
            chk({tbl[i].name, "_ovf"}, ov, tbl[i].ov);
        end

        // Sticky flag, then clear; the clamping data left in the bubbles must not re-raise it.
        clear_ovf();
        send_one(tbl[3], yr, yi, ov, lat);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ovf_sticky", ovf0, 1'b1);
        @(posedge clk); #1;
        clear_ovf();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ovf_cleared_bubble", ovf0, 1'b0);
        @(posedge clk); #1;

        // Clear asserted in the very cycle a clamping vector reaches stage B.
        x_re = tbl[3].xr; x_im = tbl[3].xi; inv = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_set_wins", ovf0, 1'b1);
        @(posedge clk); #1;

        // Backpressure: six vectors, downstream stalls on cycles 3..5.
        for (int k = 0; k < 6; k++) begin
            bp_re[k] = rnd_vec(1'b0);
            bp_im[k] = rnd_vec(1'b0);
        end
        x_re = '0; x_im = '0;
        repeat (3) @(posedge clk);
        #1;
        clear_ovf();
        exp_ov0 = 1'b0; exp_ov1 = 1'b0; n_out = 0; sb.delete();
        mon_en = 1'b1;
        sent = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (sent < 6);
            inv       = sent[0];
            if (sent < 6) begin
                x_re = bp_re[sent];
                x_im = bp_im[sent];
            end
            @(negedge clk);
            acc = in_valid && in_ready0;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        drain("bp_drain");
        chk("bp_count", n_out, 6);
        mon_en = 1'b0;

        // Randomized chunks; each begins with a cleared flag so the sticky model restarts.
        for (int ch = 0; ch < 3; ch++) begin
            @(posedge clk); #1;
            clear_ovf();
            exp_ov0 = 1'b0; exp_ov1 = 1'b0; sb.delete();
            mon_en = 1'b1;
            for (int c = 0; c < 80; c++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                inv       = 1'($urandom);
                x_re      = rnd_vec($urandom_range(0, 7) == 0);
                x_im      = rnd_vec($urandom_range(0, 7) == 0);
                @(posedge clk); #1;
            end
            drain("rnd_drain");
            mon_en = 1'b0;
        end

        // Reset while two clamping vectors are in flight.
        clear_ovf();
        x_re = tbl[3].xr; x_im = tbl[3].xi; inv = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_ovf", ovf0, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", {out_valid1, out_valid0}, 2'b00);
        chk("mid_rst_y", y_re0 | y_im0 | y_re1 | y_im1, '0);
        chk("mid_rst_ovf", {ovf1, ovf0}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen |= out_valid0 | out_valid1;
        end
        chk("no_stale", seen, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fft8_stage2_stream.md
Name: fft8_stage2_stream

Overview:
- Parametrised, handshaked successor of the fixed 8-point FFT second butterfly stage.
- Accepts one full 8-point complex vector per beat from stage 1 and applies the four stage-2 radix-2 butterflies.
- Applies the W4 twiddle to the odd difference paths: -j forward, +j inverse, selectable per beat.
- Provides optional 1/2 scaling or saturation, a sticky overflow flag, and valid/ready flow control with stall support. Output feeds the stage-3 block.

Parameters:
- W, 16, signed sample width of every real/imag component (W >= 4).
- SCALE, 0, 0 = full-scale with saturation; 1 = every butterfly output divided by 2 with rounding.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector this cycle.
- inv  in  1  per-beat mode: 0 = forward (-j), 1 = inverse (+j); sampled with data.
- x_re  in  8*W  real parts, element k at bits [k*W +: W], signed.
- x_im  in  8*W  imaginary parts, same packing.
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts the output.
- y_re  out  8*W  real results, same packing.
- y_im  out  8*W  imaginary results, same packing.
- ovf  out  1  sticky overflow/saturation flag.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (rst=0 at a clk edge): both pipeline valid bits = 0; out_valid = 0; y_re = 0; y_im = 0; ovf = 0. Data registers are cleared. Reset mid-stream discards all in-flight vectors, and no partial output appears.
- Pipeline: two register stages, A and B. Latency is exactly 2 accepted-clock cycles from an in_valid&in_ready edge to out_valid, when out_ready=1 throughout.
- Flow control:
  - en = out_ready | ~out_valid; in_ready = en (combinational).
  - When en=1, stage A loads the input, and stage B loads from stage A. Each valid bit follows its data (A.v <= in_valid, B.v <= A.v).
  - When en=0, all stages hold, and y_*/out_valid remain stable.
  - Stage-A bubbles are not collapsed during a stall.
  - Full throughput: 1 vector/cycle when out_ready stays 1.
- Stage A, on (W+1)-bit exact sums/differences:
  - s0 = x0+x2, s2 = x0-x2, s1 = x1+x3, d3 = x1-x3.
  - s4 = x4+x6, s6 = x4-x6, s5 = x5+x7, d7 = x5-x7.
  - The inv bit is registered alongside the data.
- Stage B, width reduction of each (W+1)-bit value v:
  - SCALE=1: r = (v + 1) >>> 1 (round half up). This never overflows.
  - SCALE=0: r = v clamped to [-2^(W-1), 2^(W-1)-1]; any clamp raises ovf.
- Stage B, twiddle on the reduced d3 and d7 (re, im):
  - forward: y = (im, -re).
  - inverse: y = (-im, re).
  - Negating -2^(W-1) yields 2^(W-1)-1 and raises ovf, in both SCALE modes.
- Output mapping: y0=s0, y1=s1, y2=s2, y3=T(d3), y4=s4, y5=s5, y6=s6, y7=T(d7).
- ovf behaviour:
  - Set in the cycle stage B loads a valid vector that clamps.
  - Held until reset or ovf_clr=1.
  - If ovf_clr and a new overflow occur in the same cycle, set wins (ovf=1).
  - Overflows in bubble (invalid) data are ignored.
- inv changes only take effect on the beat they accompany. Vectors in flight keep their own mode.

Test Plan:
- Impulse, W=16, SCALE=0, forward: x0=(100,0), others 0 -> after 2 cycles y0=y2=(100,0), all others (0,0), ovf=0.
- Twiddle check: x1=(300,-50), x3=0, forward -> y1=(300,-50), y3=(-50,-300). Same vector with inv=1 -> y3=(50,300).
- Saturation: x0=x2=(32767,-32768), SCALE=0 -> y0=(32767,-32768), ovf=1, ovf stays 1 until ovf_clr pulse. Same vector with SCALE=1 -> y0=(32767,-32768), ovf=0.
- Negation edge: x5=(0,-32768), x7=0, forward -> y7=(-32768... re=im=-32768 becomes y7=(-32768,0)); with x5=(-32768,0) forward -> y7=(0,32767), ovf=1.
- Backpressure: stream 6 vectors with out_ready low on cycles 3-5 -> in_ready=0 while out_valid&~out_ready, outputs stable during stall, all 6 vectors emitted in order with no loss or duplication.
- Reset mid-stream: assert rst=0 with 2 vectors in flight -> next cycle out_valid=0, y=0, ovf=0; no stale vector emerges after release.
